uart_autobaud_detect: RTL

- Automatic baud-rate detector on the UART RX path. It is the producer of the 9-bit baud reference word that the 7-segment baud display and the UART baud generator consume.
- It measures the low-pulse widths on the incoming RX line while the far end sends sync characters 0x55 ('U'). Every bit of 0x55 framed 8N1 is one bit-time wide.
- It classifies each pulse as 9600, 57600 or 115200 baud. After MATCH_N consecutive agreeing pulses it locks and drives the matching divisor.
- All timing assumes the 50 MHz system clock.

---
 rtl/uart_autobaud_detect.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_autobaud_detect.sv
// Automatic baud-rate detector: times low pulses of 0x55 sync characters on RX,
// classifies them as 9600/57600/115200 and locks after MATCH_N agreeing pulses.
module uart_autobaud_detect #(
  parameter int REF_9600   = 324,
  parameter int REF_57600  = 53,
  parameter int REF_115200 = 26,
  parameter int MIN_115200 = 300,
  parameter int MIN_57600  = 651,
  parameter int MAX_57600  = 1300,
  parameter int MIN_9600   = 3900,
  parameter int MAX_9600   = 6500,
  parameter int MATCH_N    = 2,
  parameter int CNT_W      = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rearm,
  output logic [8:0] refer,
  output logic       locked,
  output logic       err
);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_CHECK, S_LOCKED} state_t;
  typedef enum logic [1:0] {CL_NONE, CL_115200, CL_57600, CL_9600} class_t;

  localparam logic [CNT_W-1:0] L_MIN115 = CNT_W'(MIN_115200);
  localparam logic [CNT_W-1:0] L_MIN576 = CNT_W'(MIN_57600);
  localparam logic [CNT_W-1:0] L_MAX576 = CNT_W'(MAX_57600);
  localparam logic [CNT_W-1:0] L_MIN96  = CNT_W'(MIN_9600);
  localparam logic [CNT_W-1:0] L_MAX96  = CNT_W'(MAX_9600);
  localparam logic [2:0]       L_MATCH  = 3'(MATCH_N);

  state_t           r_state, w_state;
  class_t           r_last, w_last, w_class;
  logic             r_sync1, r_sync2, r_rx_prev;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [2:0]       r_match, w_match, w_inc;
  logic [8:0]       r_refer, w_refer;
  logic             r_locked, w_locked, r_err, w_err;
  logic             w_fall;

  function automatic class_t classify(input logic [CNT_W-1:0] len);
    if (len >= L_MIN115 && len < L_MIN576)  return CL_115200;
    if (len >= L_MIN576 && len <= L_MAX576) return CL_57600;
    if (len >= L_MIN96  && len <= L_MAX96)  return CL_9600;
    return CL_NONE;
  endfunction

  function automatic logic [8:0] divisor(input class_t cl);
    case (cl)
      CL_115200: return 9'(REF_115200);
      CL_57600:  return 9'(REF_57600);
      CL_9600:   return 9'(REF_9600);
      default:   return 9'd0;
    endcase
  endfunction

  assign w_fall  = r_rx_prev & ~r_sync2;
  assign w_class = classify(r_cnt);

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_match  = r_match;
    w_last   = r_last;
    w_refer  = r_refer;
    w_locked = r_locked;
    w_err    = 1'b0;
    w_inc    = (w_class == r_last) ? r_match + 3'd1 : 3'd1;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state = S_MEASURE;
          w_cnt   = CNT_W'(1);
        end
      end
      S_MEASURE: begin
        if (r_sync2) w_state = S_CHECK;
        else if (r_cnt != '1) w_cnt = r_cnt + 1'b1;
      end
      S_CHECK: begin
        if (w_class == CL_NONE) begin
          w_err   = 1'b1;
          w_match = 3'd0;
          w_last  = CL_NONE;
          w_state = S_IDLE;
        end else begin
          w_match = w_inc;
          w_last  = w_class;
          if (w_inc >= L_MATCH) begin
            w_refer  = divisor(w_class);
            w_locked = 1'b1;
            w_state  = S_LOCKED;
          end else begin
            w_state = S_IDLE;
          end
        end
      end
      default: ;
    endcase
    // rearm overrides everything, including a lock completing this cycle; refer is kept
    if (rearm) begin
      w_state  = S_IDLE;
      w_locked = 1'b0;
      w_match  = 3'd0;
      w_last   = CL_NONE;
      w_refer  = r_refer;
      w_err    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_cnt     <= '0;
      r_match   <= 3'd0;
      r_last    <= CL_NONE;
      r_refer   <= 9'd0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_match   <= w_match;
      r_last    <= w_last;
      r_refer   <= w_refer;
      r_locked  <= w_locked;
      r_err     <= w_err;
    end
  end

  assign refer  = r_refer;
  assign locked = r_locked;
  assign err    = r_err;

endmodule
